slow_tick_bcd_counter: RTL and testbench
========================================

# slow_tick_bcd_counter

Four-digit BCD up/down counter advanced by the divided slow clock from the upstream clock divider. It drives a multiplexed, active-low, common-anode seven-segment display. The slow clock is edge-detected in the `clk_i` domain and never used as a clock. The block sits directly downstream of the 100 MHz divider and directly upstream of the board display pins.

## Interface
- `REFRESH_DIV`, default 100_000: `clk_i` cycles per display digit slot (1 kHz per digit at 100 MHz). Must be ≥ 2.
- `clk_i` input, 1 bit: system clock, 100 MHz. This is the only clock.
- `rst_i` input, 1 bit: synchronous reset, active-low. It takes effect on the `clk_i` rising edge when low.
- `slow_clk_i` input, 1 bit: divided clock from the divider. It is generated from `clk_i`, so no synchronizer is needed.
- `en_i` input, 1 bit: count enable, sampled on a slow tick.
- `up_i` input, 1 bit: direction. 1 = up, 0 = down.
- `clr_i` input, 1 bit: synchronous clear of the count.
- `bcd_o` output, 16 bits: count value, 4 BCD digits. `[3:0]` is units, `[15:12]` is thousands.
- `wrap_o` output, 1 bit: one-cycle pulse on wrap-around.
- `seg_o` output, 7 bits: segments `{g,f,e,d,c,b,a}`, active-low.
- `an_o` output, 4 bits: digit anodes, one-hot active-low. Bit 0 is units.

## Operation
- **Edge detect.**
  - Register `sq <= slow_clk_i` each cycle.
  - `tick = slow_clk_i & ~sq`.
  - `sq` resets to 1, so no tick can fire immediately after reset unless a fresh 0→1 transition occurs.
- **Counter update** (priority order):
  1. Reset.
  2. `clr_i`: `bcd_o <= 0`, `wrap_o <= 0`.
  3. `tick & en_i & up_i`: BCD increment with decimal carry, per digit 9→0 with carry.
  4. `tick & en_i & ~up_i`: BCD decrement with borrow, per digit 0→9 with borrow.
  5. Otherwise: hold.
- **Wrap.**
  - Up from 9999 gives 0000 with `wrap_o = 1`.
  - Down from 0000 gives 9999 with `wrap_o = 1`.
  - `wrap_o` is registered, high for exactly one `clk_i` cycle, and coincides with the wrapped value on `bcd_o`. It is low in all other cycles.
- **Digit values.** No digit ever leaves 0–9. Digit arithmetic is 4 bits with explicit 9/0 compare; there is no binary-to-BCD conversion.
- **Scan.**
  - A refresh counter runs 0..`REFRESH_DIV`-1.
  - At its terminal value it returns to 0 and the digit index `idx` (2 bits) advances 0→1→2→3→0.
  - The scan runs continuously, independent of `en_i` and `clr_i`.
- **Display outputs.**
  - These are registered each cycle from the current `idx` and `bcd_o`.
  - `an_o <= ~(4'b0001 << idx)`.
  - `seg_o` is the active-low decode of digit `idx`. Required patterns (`gfedcba`):
    - 0 = 1000000
    - 1 = 1111001
    - 2 = 0100100
    - 3 = 0110000
    - 4 = 0011001
    - 5 = 0010010
    - 6 = 0000010
    - 7 = 1111000
    - 8 = 0000000
    - 9 = 0010000
- **Reset values.**
  - Outputs: `bcd_o` = 0, `wrap_o` = 0, `seg_o` = 7'b1111111, `an_o` = 4'b1111.
  - Internal: `idx` = 0, refresh counter = 0, `sq` = 1.
- **Reset mid-count.** Reset overrides everything in the same edge. All state returns to reset values, and no `wrap_o` is produced.

## Timing
- **Count latency.**
  - `bcd_o` changes on the first `clk_i` edge that samples `slow_clk_i` high after it was sampled low.
  - There is exactly one update per slow-clock rising edge, regardless of how long `slow_clk_i` stays high.
  - Falling edges do nothing.
- **Sampled inputs.** `en_i` and `up_i` are sampled only in the tick cycle. `clr_i` acts in any cycle.
- **Clear vs. tick.** When `clr_i` and a tick coincide, clear wins. The result is 0000 with no wrap, and that tick is lost.
- **Display latency.**
  - `an_o`/`seg_o` lag `idx`/`bcd_o` by one cycle.
  - The first valid anode (1110, digit 0) appears 1 cycle after reset release.
  - Each digit is shown for exactly `REFRESH_DIV` cycles.
- **Throughput.** A slow tick can arrive as often as every 2 `clk_i` cycles (0,1,0,1...); every rising edge must count.

## Test plan
- **Reset and scan.** Hold `rst_i` = 0 for 3 cycles → all outputs at their reset values. Release with `REFRESH_DIV` = 4 → `an_o` cycles 1110, 1101, 1011, 0111, 4 cycles each, starting 1 cycle after release.
- **Count up.** `en_i` = 1, `up_i` = 1, 12 slow rising edges → `bcd_o` = 16'h0012. Digit 1 slot shows `seg_o` = 1111001; digit 0 slot shows 0100100.
- **Wrap up / wrap down.**
  - Preset via 9999 down-count from 0: one down tick from 0000 → `bcd_o` = 16'h9999, `wrap_o` high for 1 cycle.
  - Then one up tick → 16'h0000, `wrap_o` high for 1 cycle.
- **Carry chain.** From 0999, one up tick → 1000. From 1000, one down tick → 0999. `wrap_o` stays 0 throughout.
- **Edge cases.**
  - `slow_clk_i` held high 50 cycles → exactly 1 increment.
  - `en_i` = 0 during a tick → no change.
  - `clr_i` coincident with a tick at 0045 → 0000 and no wrap.
  - 2-cycle-period `slow_clk_i` for 20 cycles → +10.
- **Reset mid-operation.** Assert `rst_i` = 0 at count 0357 during the digit-2 slot → next edge: `bcd_o` = 0, `an_o` = 1111, `seg_o` = 1111111.

Source files
------------

// File: rtl/slow_tick_bcd_counter.sv
// rtl/slow_tick_bcd_counter.sv - four-digit BCD up/down counter on slow-clock edges with multiplexed 7-seg scan
module slow_tick_bcd_counter #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        slow_clk_i,
    input  logic        en_i,
    input  logic        up_i,
    input  logic        clr_i,
    output logic [15:0] bcd_o,
    output logic        wrap_o,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    logic          sq;
    logic          tick;
    logic [RW-1:0] refresh;
    logic [1:0]    idx;
    logic [15:0]   bcd_inc;
    logic [15:0]   bcd_dec;
    logic          inc_wrap;
    logic          dec_wrap;
    logic [3:0]    cur_digit;

    assign tick = slow_clk_i & ~sq;
    assign cur_digit = bcd_o[{idx, 2'b00} +: 4];

    // Ripple the carry digit by digit; a carry out of the top digit is the wrap.
    always_comb begin
        logic carry;
        carry   = 1'b1;
        bcd_inc = bcd_o;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd_o[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_o[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        inc_wrap = carry;
    end

    always_comb begin
        logic borrow;
        borrow  = 1'b1;
        bcd_dec = bcd_o;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (bcd_o[4*i +: 4] == 4'd0) begin
                    bcd_dec[4*i +: 4] = 4'd9;
                end else begin
                    bcd_dec[4*i +: 4] = bcd_o[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        dec_wrap = borrow;
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sq      <= 1'b1;
            refresh <= '0;
            idx     <= 2'd0;
            bcd_o   <= 16'h0000;
            wrap_o  <= 1'b0;
            seg_o   <= 7'b1111111;
            an_o    <= 4'b1111;
        end else begin
            sq <= slow_clk_i;

            if (refresh == REF_LAST) begin
                refresh <= '0;
                idx     <= idx + 2'd1;
            end else begin
                refresh <= refresh + RW'(1);
            end

            an_o  <= ~(4'b0001 << idx);
            seg_o <= seg_decode(cur_digit);

            if (clr_i) begin
                bcd_o  <= 16'h0000;
                wrap_o <= 1'b0;
            end else if (tick && en_i && up_i) begin
                bcd_o  <= bcd_inc;
                wrap_o <= inc_wrap;
            end else if (tick && en_i) begin
                bcd_o  <= bcd_dec;
                wrap_o <= dec_wrap;
            end else begin
                wrap_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_slow_tick_bcd_counter.sv
// tb/tb_slow_tick_bcd_counter.sv - scoreboard bench for slow_tick_bcd_counter
module tb_slow_tick_bcd_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        slow_clk = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] bcd_o;
    logic        wrap_o;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;

    int checks = 0;
    int failures = 0;

    slow_tick_bcd_counter #(.REFRESH_DIV(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slow_clk_i (slow_clk),
        .en_i       (en),
        .up_i       (up),
        .clr_i      (clr),
        .bcd_o      (bcd_o),
        .wrap_o     (wrap_o),
        .seg_o      (seg_o),
        .an_o       (an_o)
    );

    always #5 clk = ~clk;

    // Reference state: count held as a plain integer 0..9999.
    int          m_count = 0;
    bit          m_prev = 1'b1;
    bit          m_wrap = 1'b0;
    logic [16:0] exp_q[$];
    bit          mon_en = 1'b0;
    logic [15:0] mon_last = 16'h0000;

    function automatic logic [15:0] to_bcd(input int c);
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [6:0] seg_pat(input int d);
        logic [6:0] tab [10];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (d >= 0 && d <= 9) ? tab[d] : 7'b1111111;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int old;
        bit t;
        old = m_count;
        if (!rst) begin
            m_count = 0;
            m_prev  = 1'b1;
            m_wrap  = 1'b0;
        end else begin
            t      = slow_clk && !m_prev;
            m_prev = slow_clk;
            m_wrap = 1'b0;
            if (clr) begin
                m_count = 0;
            end else if (t && en) begin
                if (up) begin
                    m_count = (m_count + 1) % 10000;
                    m_wrap  = (m_count == 0);
                end else begin
                    m_count = (m_count + 9999) % 10000;
                    m_wrap  = (m_count == 9999);
                end
            end
        end
        if (m_count != old || m_wrap) exp_q.push_back({m_wrap, to_bcd(m_count)});
    endtask

    task automatic drive(input logic s, input logic e, input logic u, input logic c);
        @(negedge clk);
        slow_clk = s;
        en = e;
        up = u;
        clr = c;
        model_step();
    endtask

    task automatic ticks(input int n, input logic u);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, u, 1'b0);
            drive(1'b0, 1'b1, u, 1'b0);
        end
    endtask

    task automatic wait_an(input logic [3:0] target);
        int n;
        n = 0;
        while (an_o !== target && n < 40) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        chk("wait_an", {28'd0, an_o}, {28'd0, target});
    endtask

    // Scoreboard monitor: every visible count change or wrap pulse consumes one expected entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bcd_o !== mon_last || wrap_o !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got bcd=%h wrap=%b with no expected event at %0t",
                             bcd_o, wrap_o, $time);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    if ({wrap_o, bcd_o} !== e) begin
                        failures++;
                        $display("FAIL sb_event: got bcd=%h wrap=%b expected bcd=%h wrap=%b at %0t",
                                 bcd_o, wrap_o, e[15:0], e[16], $time);
                    end
                end
            end
            if (an_o !== 4'b1111) begin
                int d;
                case (an_o)
                    4'b1110: d = 0;
                    4'b1101: d = 1;
                    4'b1011: d = 2;
                    4'b0111: d = 3;
                    default: d = -1;
                endcase
                checks++;
                if (d < 0) begin
                    failures++;
                    $display("FAIL an_onehot: got %b at %0t", an_o, $time);
                end else if (seg_o !== seg_pat(int'(mon_last[4*d +: 4]))) begin
                    failures++;
                    $display("FAIL seg_decode: got %b expected %b digit %0d at %0t",
                             seg_o, seg_pat(int'(mon_last[4*d +: 4])), d, $time);
                end
            end
            mon_last = bcd_o;
        end
    end

    initial begin
        // Reset and scan
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst = 1'b0;
            model_step();
        end
        @(negedge clk);
        chk("rst_bcd", {16'd0, bcd_o}, 32'h0);
        chk("rst_wrap", {31'd0, wrap_o}, 32'h0);
        chk("rst_seg", {25'd0, seg_o}, 32'h7f);
        chk("rst_an", {28'd0, an_o}, 32'hf);
        rst = 1'b1;
        model_step();
        mon_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            chk("scan_an", {28'd0, an_o}, {28'd0, ~(4'b0001 << (k / 4))});
        end

        // Count up with irregular slow-clock duty
        for (int i = 0; i < 12; i++) begin
            int hi;
            int lo;
            hi = $urandom_range(1, 3);
            lo = $urandom_range(1, 3);
            for (int j = 0; j < hi; j++) drive(1'b1, 1'b1, 1'b1, 1'b0);
            for (int j = 0; j < lo; j++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        end
        chk("count_up_12", {16'd0, bcd_o}, 32'h0012);
        wait_an(4'b1101);
        chk("seg_digit1", {25'd0, seg_o}, {25'd0, 7'b1111001});
        wait_an(4'b1110);
        chk("seg_digit0", {25'd0, seg_o}, {25'd0, 7'b0100100});

        // Wrap down then up
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_down_bcd", {16'd0, bcd_o}, 32'h9999);
        chk("wrap_down_pulse", {31'd0, wrap_o}, 32'h1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_down_end", {31'd0, wrap_o}, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("wrap_up_bcd", {16'd0, bcd_o}, 32'h0000);
        chk("wrap_up_pulse", {31'd0, wrap_o}, 32'h1);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("wrap_up_end", {31'd0, wrap_o}, 32'h0);

        // Carry chain
        ticks(999, 1'b1);
        chk("carry_0999", {16'd0, bcd_o}, 32'h0999);
        ticks(1, 1'b1);
        chk("carry_1000", {16'd0, bcd_o}, 32'h1000);
        ticks(1, 1'b0);
        chk("borrow_0999", {16'd0, bcd_o}, 32'h0999);

        // Long high level counts once
        for (int i = 0; i < 50; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("long_high", {16'd0, bcd_o}, 32'h1000);

        // Disabled tick
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("en_low", {16'd0, bcd_o}, 32'h1000);

        // Clear beats coincident tick
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        ticks(45, 1'b1);
        chk("pre_clr_0045", {16'd0, bcd_o}, 32'h0045);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("clr_tick_bcd", {16'd0, bcd_o}, 32'h0000);
        chk("clr_tick_wrap", {31'd0, wrap_o}, 32'h0);

        // Fastest slow clock: 20 cycles, 10 edges
        for (int i = 0; i < 20; i++) drive(1'(i % 2 == 0), 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("fast_plus10", {16'd0, bcd_o}, 32'h0010);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("random_final", {16'd0, bcd_o}, {16'd0, to_bcd(m_count)});

        // Reset mid-operation
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        ticks(357, 1'b1);
        chk("pre_rst_0357", {16'd0, bcd_o}, 32'h0357);
        wait_an(4'b1011);
        rst = 1'b0;
        model_step();
        @(negedge clk);
        chk("mid_rst_bcd", {16'd0, bcd_o}, 32'h0);
        chk("mid_rst_an", {28'd0, an_o}, 32'hf);
        chk("mid_rst_seg", {25'd0, seg_o}, 32'h7f);
        chk("mid_rst_wrap", {31'd0, wrap_o}, 32'h0);
        rst = 1'b1;
        model_step();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
